jt7759_cengen: RTL

JT7759_CENGEN -- requirements
Module: jt7759_cengen

---
 rtl/jt7759_pkg.sv | 6 +
 rtl/jt7759_cengen_ch.sv | 54 +++++
 rtl/jt7759_cengen.sv | 64 ++++++
 3 files changed

// File: rtl/jt7759_pkg.sv
// Shared defaults for the JT7759 clock-enable generator.
package jt7759_pkg;
  localparam int unsigned JT7759_PRE = 4;
  localparam int unsigned JT7759_DW  = 6;
  localparam int unsigned JT7759_CH  = 2;
endpackage

// File: rtl/jt7759_cengen_ch.sv
// One divided-enable channel: counts prescaled pulses up to a latched terminal count.
module jt7759_cengen_ch
  import jt7759_pkg::*;
#(
  parameter int unsigned DW = JT7759_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pre,
  input  logic          sync,
  input  logic          en,
  input  logic [DW-1:0] divby,
  output logic          cendiv
);

  logic [DW-1:0] act_q, act_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          cendiv_q, cendiv_d;
  logic          hit;
  logic          wrap;

  always_comb begin
    hit      = (cnt_q == act_q);
    wrap     = pre && en && hit;
    act_d    = act_q;
    cnt_d    = cnt_q;
    cendiv_d = wrap && !sync;
    // divby is only sampled at period boundaries so a mid-period change cannot alter the running period
    if (sync || !en) begin
      cnt_d = '0;
      act_d = divby;
    end else if (wrap) begin
      cnt_d = '0;
      act_d = divby;
    end else if (pre) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q    <= divby;
      cnt_q    <= '0;
      cendiv_q <= 1'b0;
    end else begin
      act_q    <= act_d;
      cnt_q    <= cnt_d;
      cendiv_q <= cendiv_d;
    end
  end

  assign cendiv = cendiv_q;

endmodule

// File: rtl/jt7759_cengen.sv
// Prescaler on the base enable plus CH independent divided-enable channels.
module jt7759_cengen
  import jt7759_pkg::*;
#(
  parameter int unsigned PRE = JT7759_PRE,
  parameter int unsigned DW  = JT7759_DW,
  parameter int unsigned CH  = JT7759_CH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic           sync,
  input  logic [CH-1:0]  en,
  input  logic [CH*DW-1:0] divby,
  output logic           cenpre,
  output logic [CH-1:0]  cendiv
);

  localparam int unsigned PW = $clog2(PRE);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          cenpre_q, cenpre_d;
  logic          pre;

  always_comb begin
    pre       = cen && (pre_cnt_q == PW'(PRE - 1));
    pre_cnt_d = pre_cnt_q;
    if (sync) begin
      pre_cnt_d = '0;
    end else if (pre) begin
      pre_cnt_d = '0;
    end else if (cen) begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
    cenpre_d = pre && !sync;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      cenpre_q  <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cenpre_q  <= cenpre_d;
    end
  end

  assign cenpre = cenpre_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    jt7759_cengen_ch #(
      .DW(DW)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .pre   (pre),
      .sync  (sync),
      .en    (en[i]),
      .divby (divby[i*DW +: DW]),
      .cendiv(cendiv[i])
    );
  end

endmodule
